// File: rtl/multiscale_detect_ctrl_pkg.sv
// Shared types for the multi-scale detection controller: FSM states,
// serialiser word select and the queued hit record.
package detect_pkg;

    localparam int COORD_WIDTH = 12;

    typedef enum logic [1:0] {
        WAIT_REQ = 2'd0,
        SCAN     = 2'd1,
        READY    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        W_X = 2'd0,
        W_Y = 2'd1,
        W_S = 2'd2
    } word_sel_e;

    // Field order puts x in the low bits so a record reads {scale, y, x}.
    typedef struct packed {
        logic [COORD_WIDTH-1:0] scale;
        logic [COORD_WIDTH-1:0] y;
        logic [COORD_WIDTH-1:0] x;
    } result_rec_t;

endpackage

// File: rtl/multiscale_detect_ctrl_if.sv
// Host-side pixel and result handshakes of the detection controller.
interface multiscale_detect_ctrl_if #(
    parameter int COORD_WIDTH = detect_pkg::COORD_WIDTH
);
    logic                   recieve_pixel;
    logic                   o_fpga_ready_recieve_pixel;
    logic                   o_recieve_pixel_end;
    logic [COORD_WIDTH-1:0] o_ori_x;
    logic [COORD_WIDTH-1:0] o_ori_y;
    logic                   o_frame_end;
    logic                   trig_send_result;
    logic                   result_sent;
    logic [COORD_WIDTH-1:0] o_result_data;
    logic                   o_fpga_ready_send_result;
    logic                   o_result_end;
    logic                   o_overflow;

    modport master (
        output recieve_pixel, trig_send_result, result_sent,
        input  o_fpga_ready_recieve_pixel, o_recieve_pixel_end, o_ori_x, o_ori_y,
               o_frame_end, o_result_data, o_fpga_ready_send_result, o_result_end,
               o_overflow
    );

    modport slave (
        input  recieve_pixel, trig_send_result, result_sent,
        output o_fpga_ready_recieve_pixel, o_recieve_pixel_end, o_ori_x, o_ori_y,
               o_frame_end, o_result_data, o_fpga_ready_send_result, o_result_end,
               o_overflow
    );
endinterface

// File: rtl/multiscale_detect_ctrl_fifo.sv
// Show-ahead synchronous FIFO holding hit records until the host reads them.
module result_fifo #(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and count define validity, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/multiscale_detect_ctrl.sv
// Frame-level controller: pixel handshake and coordinate tracking, per-scale
// hit aggregation into a result FIFO, and 12-bit word readout to the host.
module multiscale_detect_ctrl
    import detect_pkg::*;
#(
    parameter int FRAME_WIDTH  = 800,
    parameter int FRAME_HEIGHT = 600,
    parameter int NUM_RESIZE   = 5,
    parameter int RESULT_DEPTH = 64,
    parameter int REQUEST_ALL  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  database_load_done,
    input  logic [NUM_RESIZE-1:0] pixel_request,
    input  logic [NUM_RESIZE-1:0] candidate,
    multiscale_detect_ctrl_if.slave host
);
    localparam int IDX_W = (NUM_RESIZE > 1) ? $clog2(NUM_RESIZE) : 1;
    localparam int REC_W = $bits(result_rec_t);
    localparam int CNT_W = $clog2(RESULT_DEPTH + 1);

    logic [1:0]             state;
    logic [NUM_RESIZE-1:0]  mask;
    logic [NUM_RESIZE-1:0]  mask_clr;
    logic [IDX_W-1:0]       scan_idx;
    logic                   req;
    logic                   accept;
    logic                   ready_q;
    logic                   overflow_q;
    logic                   pixel_end_q;
    logic                   frame_end_q;
    logic                   last_x;
    logic                   last_y;
    logic [COORD_WIDTH-1:0] ori_x;
    logic [COORD_WIDTH-1:0] ori_y;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    result_rec_t            push_rec;
    result_rec_t            head_rec;
    result_rec_t            send_rec;
    logic [1:0]             word_sel;
    logic                   send_valid;
    logic                   send_step;
    logic                   send_last;
    logic                   send_load;
    logic                   send_reload;

    assign req    = database_load_done &&
                    ((REQUEST_ALL != 0) ? &pixel_request : |pixel_request);
    assign accept = (state == READY) && ready_q && host.recieve_pixel;
    assign last_x = (ori_x == COORD_WIDTH'(FRAME_WIDTH - 1));
    assign last_y = (ori_y == COORD_WIDTH'(FRAME_HEIGHT - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        scan_idx = '0;
        for (int i = NUM_RESIZE - 1; i >= 0; i--) begin
            if (mask[i]) scan_idx = IDX_W'(i);
        end
        mask_clr = mask & ~(NUM_RESIZE'(1) << scan_idx);
    end

    always_comb begin
        push_rec.scale = COORD_WIDTH'(scan_idx);
        push_rec.y     = ori_y;
        push_rec.x     = ori_x;
    end

    assign fifo_push = (state == SCAN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_REQ;
            mask       <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                WAIT_REQ: if (req) begin
                    mask  <= candidate;
                    state <= (|candidate) ? SCAN : READY;
                end
                SCAN: begin
                    mask <= mask_clr;
                    if (fifo_full)       overflow_q <= 1'b1;
                    if (mask_clr == '0)  state      <= READY;
                end
                READY:   if (accept) state <= WAIT_REQ;
                default: state <= WAIT_REQ;
            endcase
            // Ready is registered one cycle behind READY so it drops right after an accept.
            ready_q <= (state == READY) && !accept;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ori_x       <= '0;
            ori_y       <= '0;
            pixel_end_q <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            pixel_end_q <= accept;
            frame_end_q <= accept && last_x && last_y;
            if (accept) begin
                if (last_x) begin
                    ori_x <= '0;
                    ori_y <= last_y ? '0 : ori_y + 1'b1;
                end else begin
                    ori_x <= ori_x + 1'b1;
                end
            end
        end
    end

    result_fifo #(
        .WIDTH (REC_W),
        .DEPTH (RESULT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (push_rec),
        .pop   (fifo_pop),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Trigger is only consulted at record boundaries, so a drop mid-record still drains it.
    assign send_step   = send_valid && host.result_sent;
    assign send_last   = send_step && (word_sel == W_S);
    assign send_load   = !send_valid && !fifo_empty && host.trig_send_result;
    assign send_reload = send_last && !fifo_empty && host.trig_send_result;
    assign fifo_pop    = send_load || send_reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            send_valid <= 1'b0;
            word_sel   <= W_X;
            send_rec   <= '0;
        end else if (fifo_pop) begin
            send_rec   <= head_rec;
            word_sel   <= W_X;
            send_valid <= 1'b1;
        end else if (send_last) begin
            send_valid <= 1'b0;
        end else if (send_step) begin
            word_sel <= (word_sel == W_X) ? W_Y : W_S;
        end
    end

    always_comb begin
        case (word_sel)
            W_X:     host.o_result_data = send_rec.x;
            W_Y:     host.o_result_data = send_rec.y;
            default: host.o_result_data = send_rec.scale;
        endcase
    end

    assign host.o_fpga_ready_recieve_pixel = ready_q;
    assign host.o_recieve_pixel_end        = pixel_end_q;
    assign host.o_frame_end                = frame_end_q;
    assign host.o_ori_x                    = ori_x;
    assign host.o_ori_y                    = ori_y;
    assign host.o_fpga_ready_send_result   = send_valid;
    assign host.o_result_end               = (fifo_count == '0) && !send_valid;
    assign host.o_overflow                 = overflow_q;
endmodule
